// File: rtl/complex_alu_sched_pkg.sv
// rtl/complex_alu_sched_pkg.sv - opcodes, widths and DSP control encodings for the complex ALU scheduler
package complex_alu_sched_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int ALUMODE_WIDTH = 4;
  localparam int INMODE_WIDTH  = 5;
  localparam int OPMODE_WIDTH  = 7;

  localparam logic [2:0] OP_MUL    = 3'b100;
  localparam logic [2:0] OP_MULSUB = 3'b110;
  localparam logic [2:0] OP_MULADD = 3'b111;

  localparam logic [OPMODE_WIDTH-1:0]  OPMODE_M     = 7'b0000101;
  localparam logic [OPMODE_WIDTH-1:0]  OPMODE_CM    = 7'b0110101;
  localparam logic [ALUMODE_WIDTH-1:0] ALUMODE_ADD  = 4'b0000;
  localparam logic [ALUMODE_WIDTH-1:0] ALUMODE_ZSUB = 4'b0011;
  localparam logic [INMODE_WIDTH-1:0]  INMODE_A2B2  = 5'b00000;

  typedef struct packed {
    logic [4*ALUMODE_WIDTH-1:0] alumode;
    logic [4*INMODE_WIDTH-1:0]  inmode;
    logic [4*OPMODE_WIDTH-1:0]  opmode;
    logic [3:0]                 cea2;
    logic [3:0]                 ceb2;
    logic [3:0]                 usemult;
    logic                       legal;
  } dsp_ctl_t;

  // Core 1 sits in the MSBs; cores 1 and 3 form the real/imag accumulator lanes.
  function automatic dsp_ctl_t decode_op(input logic [2:0] op);
    dsp_ctl_t c;
    c = '0;
    case (op)
      OP_MUL, OP_MULSUB, OP_MULADD: begin
        c.legal   = 1'b1;
        c.cea2    = 4'b1111;
        c.ceb2    = 4'b1111;
        c.usemult = 4'b1111;
        c.inmode  = {4{INMODE_A2B2}};
        c.opmode  = {4{OPMODE_M}};
        c.alumode = {4{ALUMODE_ADD}};
        if (op != OP_MUL) begin
          c.opmode = {OPMODE_CM, OPMODE_M, OPMODE_CM, OPMODE_M};
        end
        if (op == OP_MULSUB) begin
          c.alumode = {ALUMODE_ZSUB, ALUMODE_ADD, ALUMODE_ZSUB, ALUMODE_ADD};
        end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/calu_res_fifo.sv
// rtl/calu_res_fifo.sv - first-word fall-through result FIFO holding {data, tag}
module calu_res_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 36
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic                     out_valid,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
    end
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_valid = (count_q != '0);
  assign rdata     = mem_q[rd_ptr_q];
  assign count     = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/complex_alu_sched.sv
// rtl/complex_alu_sched.sv - issue controller and result sequencer for the 4-DSP complex ALU
// Optional perf counters are built when CALU_PERF_CNT_EN is defined.
module complex_alu_sched
  import complex_alu_sched_pkg::*;
#(
  parameter int ALU_LAT   = 5,
  parameter int RES_DEPTH = 8,
  parameter int TAG_W     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  in_opcode,
  input  logic [TAG_W-1:0]            in_tag,
  input  logic [2*DATA_WIDTH-1:0]     in_din_1,
  input  logic [2*DATA_WIDTH-1:0]     in_din_2,
  input  logic [2*DATA_WIDTH-1:0]     in_din_3,
  output logic [2:0]                  alu_opcode,
  output logic [4*ALUMODE_WIDTH-1:0]  alu_alumode,
  output logic [4*INMODE_WIDTH-1:0]   alu_inmode,
  output logic [4*OPMODE_WIDTH-1:0]   alu_opmode,
  output logic [3:0]                  alu_cea2,
  output logic [3:0]                  alu_ceb2,
  output logic [3:0]                  alu_usemult,
  output logic [2*DATA_WIDTH-1:0]     alu_din_1,
  output logic [2*DATA_WIDTH-1:0]     alu_din_2,
  output logic [2*DATA_WIDTH-1:0]     alu_din_3,
  input  logic [2*DATA_WIDTH-1:0]     alu_dout,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*DATA_WIDTH-1:0]     out_data,
  output logic [TAG_W-1:0]            out_tag,
  output logic                        err_illegal,
  output logic                        busy
`ifdef CALU_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_issued,
  output logic [31:0]                 perf_stall,
  output logic [15:0]                 perf_illegal
`endif
);

  localparam int DW2   = 2 * DATA_WIDTH;
  localparam int CNT_W = $clog2(RES_DEPTH) + 1;
  localparam int SUM_W = $clog2(RES_DEPTH + ALU_LAT + 2) + 1;

  dsp_ctl_t                      ctl, ctl_q, ctl_d;
  logic [2:0]                    op_q, op_d;
  logic [DW2-1:0]                din1_q, din1_d, din2_q, din2_d, din3_q, din3_d;
  logic [TAG_W-1:0]              issue_tag_q, issue_tag_d;
  logic [ALU_LAT-1:0]            vpipe_q, vpipe_d;
  logic [ALU_LAT-1:0][TAG_W-1:0] tpipe_q, tpipe_d;
  logic                          in_ready_q, in_ready_d;
  logic                          err_q, err_d;
  logic                          busy_q, busy_d;

  logic                          accept, legal_acc, push, pop;
  logic [CNT_W-1:0]              fifo_count, count_d;
  logic [SUM_W-1:0]              total_d;

  assign accept    = in_valid & in_ready_q;
  assign legal_acc = accept & ctl.legal;
  assign push      = vpipe_q[ALU_LAT-1];
  assign pop       = out_valid & out_ready;

  always_comb begin
    ctl         = decode_op(in_opcode);
    ctl_d       = '0;
    op_d        = '0;
    din1_d      = '0;
    din2_d      = '0;
    din3_d      = '0;
    issue_tag_d = '0;
    if (legal_acc) begin
      ctl_d       = ctl;
      op_d        = in_opcode;
      din1_d      = in_din_1;
      din2_d      = in_din_2;
      din3_d      = in_din_3;
      issue_tag_d = in_tag;
    end
    vpipe_d = {vpipe_q[ALU_LAT-2:0], ctl_q.legal};
    tpipe_d = {tpipe_q[ALU_LAT-2:0], issue_tag_q};

    count_d = fifo_count;
    if (push && !pop) begin
      count_d = fifo_count + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = fifo_count - CNT_W'(1);
    end

    // Every legal op is counted exactly once: issue reg, valid pipe, or FIFO.
    total_d = SUM_W'(count_d) + SUM_W'(ctl_d.legal);
    for (int i = 0; i < ALU_LAT; i++) begin
      total_d = total_d + SUM_W'(vpipe_d[i]);
    end
    in_ready_d = (total_d < SUM_W'(RES_DEPTH));
    busy_d     = (total_d != '0);
    err_d      = accept & ~ctl.legal;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_q       <= '0;
      op_q        <= '0;
      din1_q      <= '0;
      din2_q      <= '0;
      din3_q      <= '0;
      issue_tag_q <= '0;
      vpipe_q     <= '0;
      tpipe_q     <= '0;
      in_ready_q  <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ctl_q       <= ctl_d;
      op_q        <= op_d;
      din1_q      <= din1_d;
      din2_q      <= din2_d;
      din3_q      <= din3_d;
      issue_tag_q <= issue_tag_d;
      vpipe_q     <= vpipe_d;
      tpipe_q     <= tpipe_d;
      in_ready_q  <= in_ready_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  calu_res_fifo #(
    .DEPTH (RES_DEPTH),
    .W     (DW2 + TAG_W)
  ) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push),
    .wdata     ({alu_dout, tpipe_q[ALU_LAT-1]}),
    .pop       (pop),
    .out_valid (out_valid),
    .rdata     ({out_data, out_tag}),
    .count     (fifo_count)
  );

  assign in_ready    = in_ready_q;
  assign err_illegal = err_q;
  assign busy        = busy_q;
  assign alu_opcode  = op_q;
  assign alu_alumode = ctl_q.alumode;
  assign alu_inmode  = ctl_q.inmode;
  assign alu_opmode  = ctl_q.opmode;
  assign alu_cea2    = ctl_q.cea2;
  assign alu_ceb2    = ctl_q.ceb2;
  assign alu_usemult = ctl_q.usemult;
  assign alu_din_1   = din1_q;
  assign alu_din_2   = din2_q;
  assign alu_din_3   = din3_q;

`ifdef CALU_PERF_CNT_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_illegal_q, perf_illegal_d;

  always_comb begin
    perf_issued_d  = perf_issued_q + 32'(legal_acc);
    perf_stall_d   = perf_stall_q + 32'(in_valid & ~in_ready_q);
    perf_illegal_d = perf_illegal_q + 16'(err_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issued_q  <= '0;
      perf_stall_q   <= '0;
      perf_illegal_q <= '0;
    end else begin
      perf_issued_q  <= perf_issued_d;
      perf_stall_q   <= perf_stall_d;
      perf_illegal_q <= perf_illegal_d;
    end
  end

  assign perf_issued  = perf_issued_q;
  assign perf_stall   = perf_stall_q;
  assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: tb/tb_complex_alu_sched.sv
// tb/tb_complex_alu_sched.sv - randomized self-checking bench for complex_alu_sched
module tb_complex_alu_sched;

  localparam int L  = 5;
  localparam int D  = 8;
  localparam int TW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  in_opcode;
  logic [TW-1:0] in_tag;
  logic [31:0] in_din_1, in_din_2, in_din_3;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_alumode;
  logic [19:0] alu_inmode;
  logic [27:0] alu_opmode;
  logic [3:0]  alu_cea2, alu_ceb2, alu_usemult;
  logic [31:0] alu_din_1, alu_din_2, alu_din_3, alu_dout;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [TW-1:0] out_tag;
  logic        err_illegal, busy;
`ifdef CALU_PERF_CNT_EN
  logic [31:0] perf_issued, perf_stall;
  logic [15:0] perf_illegal;
`endif

  complex_alu_sched #(.ALU_LAT(L), .RES_DEPTH(D), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_tag(in_tag),
    .in_din_1(in_din_1), .in_din_2(in_din_2), .in_din_3(in_din_3),
    .alu_opcode(alu_opcode), .alu_alumode(alu_alumode), .alu_inmode(alu_inmode),
    .alu_opmode(alu_opmode), .alu_cea2(alu_cea2), .alu_ceb2(alu_ceb2),
    .alu_usemult(alu_usemult), .alu_din_1(alu_din_1), .alu_din_2(alu_din_2),
    .alu_din_3(alu_din_3), .alu_dout(alu_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .err_illegal(err_illegal), .busy(busy)
`ifdef CALU_PERF_CNT_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall), .perf_illegal(perf_illegal)
`endif
  );

  always #5 clk = ~clk;

  // Complex multiply-accumulate reference: {re,im} of W*(c+jd), optionally added to / subtracted from {a,b}.
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] d1,
                                          input logic [31:0] d2, input logic [31:0] d3);
    int wi, wq, c, d, a, b, re, im;
    wi = int'($signed(d1[31:16])); wq = int'($signed(d1[15:0]));
    c  = int'($signed(d2[31:16])); d  = int'($signed(d2[15:0]));
    a  = int'($signed(d3[31:16])); b  = int'($signed(d3[15:0]));
    re = wi * c - wq * d;
    im = wi * d + wq * c;
    case (op)
      3'b100: ;
      3'b111: begin re = a + re; im = b + im; end
      3'b110: begin re = a - re; im = b - im; end
      default: return 32'hDEAD_BEEF;
    endcase
    return {re[15:0], im[15:0]};
  endfunction

  // Stand-in for the DSP ALU: fixed L-cycle pipeline that cannot stall.
  logic [31:0] alu_pipe [L];
  always @(posedge clk) begin
    alu_pipe[0] <= ref_alu(alu_opcode, alu_din_1, alu_din_2, alu_din_3);
    for (int i = 1; i < L; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_dout = alu_pipe[L-1];

  function automatic void exp_ctl(input logic [2:0] op, output logic [27:0] opm,
                                  output logic [15:0] alm, output logic [3:0] ce);
    logic lg;
    lg  = (op == 3'b100) || (op == 3'b110) || (op == 3'b111);
    opm = '0;
    alm = '0;
    ce  = lg ? 4'hF : 4'h0;
    for (int k = 1; k <= 4; k++) begin
      if (lg) begin
        opm[(4-k)*7 +: 7] = (op != 3'b100 && (k % 2 == 1)) ? 7'b0110101 : 7'b0000101;
        alm[(4-k)*4 +: 4] = (op == 3'b110 && (k % 2 == 1)) ? 4'b0011 : 4'b0000;
      end
    end
  endfunction

  typedef struct {
    logic [31:0]   data;
    logic [TW-1:0] tag;
    int            rdy;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          n_acc = 0;
  logic [TW-1:0] tag_ctr = '0;
  logic        iss_v = 0, iss_err = 0;
  logic [2:0]  iss_op = '0;
  logic [31:0] iss_d1, iss_d2, iss_d3;
  logic        ovr_en = 0;
  logic [31:0] ovr_val = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input logic v, input logic [2:0] op, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [31:0] d3, input logic ordy);
    logic [27:0] eo;
    logic [15:0] ea;
    logic [3:0]  ec;
    logic        acc, lg;
    exp_t        e;
    @(negedge clk);
    cyc++;
    exp_ctl(iss_op, eo, ea, ec);
    check("alu_opcode", alu_opcode, iss_op);
    check("alu_opmode", alu_opmode, eo);
    check("alu_alumode", alu_alumode, ea);
    check("alu_cea2", alu_cea2, ec);
    check("alu_ceb2", alu_ceb2, ec);
    check("alu_usemult", alu_usemult, ec);
    check("alu_inmode", alu_inmode, 0);
    if (iss_v) begin
      check("alu_din_1", alu_din_1, iss_d1);
      check("alu_din_2", alu_din_2, iss_d2);
      check("alu_din_3", alu_din_3, iss_d3);
    end
    check("err_illegal", err_illegal, iss_err);
    check("in_ready", in_ready, q.size() < D);
    check("busy", busy, q.size() != 0);
    check("out_valid", out_valid, (q.size() != 0) && (q[0].rdy <= cyc));
    if (out_valid && q.size() != 0) begin
      check("out_data", out_data, q[0].data);
      check("out_tag", out_tag, q[0].tag);
    end

    in_valid = v; in_opcode = op; in_tag = tag_ctr;
    in_din_1 = d1; in_din_2 = d2; in_din_3 = d3; out_ready = ordy;

    if (ordy && out_valid && q.size() != 0) void'(q.pop_front());
    acc     = v && in_ready;
    lg      = (op == 3'b100) || (op == 3'b110) || (op == 3'b111);
    iss_v   = acc && lg;
    iss_err = acc && !lg;
    iss_op  = iss_v ? op : 3'b000;
    iss_d1 = d1; iss_d2 = d2; iss_d3 = d3;
    if (iss_v) begin
      e.data = ovr_en ? ovr_val : ref_alu(op, d1, d2, d3);
      e.tag  = tag_ctr;
      e.rdy  = cyc + L + 2;
      q.push_back(e);
    end
    if (acc) begin
      n_acc++;
      tag_ctr++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 3'b000, '0, '0, '0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_illegal, 0);
    check("rst_cea2", alu_cea2, 0);
    check("rst_opcode", alu_opcode, 0);
    check("rst_din_1", alu_din_1, 0);
    q.delete();
    iss_v = 0; iss_err = 0; iss_op = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [2:0] rand_op(input bit allow_illegal);
    int r;
    r = allow_illegal ? $urandom_range(0, 9) : $urandom_range(0, 8);
    if (r < 3) return 3'b100;
    if (r < 6) return 3'b110;
    if (r < 9) return 3'b111;
    return 3'($urandom_range(0, 3));
  endfunction

  initial begin
    int acc0;
    rst = 1'b0; in_valid = 0; in_opcode = '0; in_tag = '0;
    in_din_1 = '0; in_din_2 = '0; in_din_3 = '0; out_ready = 0;
    do_reset();

    ovr_en = 1; ovr_val = {16'hFFFB, 16'd10};
    tick(1'b1, 3'b100, {16'd3, 16'd4}, {16'd1, 16'd2}, 32'h0, 1'b1);
    ovr_en = 0;
    idle(10);
    ovr_en = 1; ovr_val = {16'd5, 16'd30};
    tick(1'b1, 3'b111, {16'd3, 16'd4}, {16'd1, 16'd2}, {16'd10, 16'd20}, 1'b1);
    ovr_val = {16'd15, 16'd10};
    tick(1'b1, 3'b110, {16'd3, 16'd4}, {16'd1, 16'd2}, {16'd10, 16'd20}, 1'b1);
    ovr_en = 0;
    idle(10);

    tag_ctr = '0;
    for (int i = 0; i < 20; i++)
      tick(1'b1, rand_op(0), $urandom, $urandom, $urandom, 1'b1);
    idle(12);

    tick(1'b1, 3'b011, $urandom, $urandom, $urandom, 1'b1);
    idle(10);

    acc0 = n_acc;
    for (int i = 0; i < 20; i++)
      tick(1'b1, rand_op(0), $urandom, $urandom, $urandom, 1'b0);
    check("flood_accepts", n_acc - acc0, D);
    idle(20);

    for (int i = 0; i < 400; i++)
      tick(1'($urandom_range(0, 1)), rand_op(1), $urandom, $urandom, $urandom,
           1'($urandom_range(0, 3) != 0));
    idle(20);

    for (int i = 0; i < 3; i++)
      tick(1'b1, rand_op(0), $urandom, $urandom, $urandom, 1'b1);
    do_reset();
    idle(15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/complex_alu_sched.md
Name: complex_alu_sched

Overview:
Issue controller and result sequencer for the 4-DSP complex ALU. It accepts tagged complex-op requests over a valid/ready handshake and decodes each opcode into per-DSP ALUMODE/INMODE/OPMODE/CE/USEMULT vectors. It drives the ALU operands and tracks the fixed ALU pipeline latency, then captures results with their tags into a result FIFO. Credit accounting guarantees that no in-flight result is dropped, because the ALU pipeline cannot stall.

Parameters:
ALU_LAT, 5, cycles from alu_* outputs presented to matching alu_dout
RES_DEPTH, 8, result FIFO entries (power of two, >= ALU_LAT+1)
TAG_W, 4, request tag width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_opcode  in  3  100 MUL, 110 MULSUB, 111 MULADD; others illegal
in_tag  in  TAG_W  request tag
in_din_1  in  2*DATA_WIDTH  {Wi,Wq}
in_din_2  in  2*DATA_WIDTH  {c,d}
in_din_3  in  2*DATA_WIDTH  {a,b} accumulator (ignored for MUL)
alu_opcode  out  3  to ALU opcode
alu_alumode  out  4*ALUMODE_WIDTH  core1 in MSBs
alu_inmode  out  4*INMODE_WIDTH
alu_opmode  out  4*OPMODE_WIDTH
alu_cea2, alu_ceb2, alu_usemult  out  4 each  bit3 = core1
alu_din_1, alu_din_2, alu_din_3  out  2*DATA_WIDTH each
alu_dout  in  2*DATA_WIDTH  {i,q} from ALU
out_valid  out  1  result available
out_ready  in  1  result consumed when out_valid & out_ready
out_data  out  2*DATA_WIDTH  {i,q}
out_tag  out  TAG_W
err_illegal  out  1  one-cycle pulse when an illegal opcode is accepted
busy  out  1  any op in flight or FIFO non-empty

Behaviour:
- Reset (rst=0, asynchronous): all alu_* = 0, in_ready=0, out_valid=0, err_illegal=0, busy=0. Valid shift register, tag pipe, FIFO pointers and counts are cleared. Any in-flight ops are discarded; late alu_dout values are ignored. in_ready rises on the first clock after reset release.
- Credit: free = RES_DEPTH - fifo_count - inflight, where inflight = number of set bits in the issue register plus the valid pipe. in_ready = (free != 0), registered and updated every cycle, including pops in the same cycle.
- Issue stage (registered, one cycle): on accept, the next cycle presents alu_din_* = in_din_*, alu_opcode = in_opcode, cea2 = ceb2 = usemult = 4'b1111, inmode = 0 on all cores.
  - MUL: opmode 0000101 on all cores; alumode 0000 on all cores.
  - MULADD: cores 1 and 3 opmode 0110101 (C+M), alumode 0000; cores 2 and 4 opmode 0000101, alumode 0000.
  - MULSUB: as MULADD, but cores 1 and 3 alumode 0011 (C-M).
- Idle cycle or illegal opcode: all control vectors 0 and alu_opcode = 000. An illegal opcode is accepted and consumes no credit; err_illegal pulses and nothing is issued.
- Valid/tag pipe: depth ALU_LAT, shifted every cycle. When the tail bit is set, alu_dout and the tag are pushed into the FIFO in that cycle.
- Total latency: accept edge to FIFO entry is ALU_LAT+1 cycles. out_valid asserts the following cycle if the FIFO was empty.
- FIFO: first-word fall-through; out_data/out_tag are stable while out_valid & !out_ready. Push and pop in the same cycle leave the count unchanged. Overflow is impossible by credit; an assertion checks push while full.
- Back-to-back issue: one op per cycle sustained while out_ready=1.

Optional Feature:
CALU_PERF_CNT_EN
- Defined: adds outputs perf_issued[31:0] (legal ops issued), perf_stall[31:0] (cycles with in_valid & !in_ready) and perf_illegal[15:0]. All wrap on overflow, are cleared by rst, and are free-running otherwise.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header (parameters.vh): opcode constants OP_MUL/OP_MULSUB/OP_MULADD; DSP control encodings (OPMODE_M, OPMODE_CM, ALUMODE_ADD, ALUMODE_ZSUB, INMODE_A2B2); widths from existing macros.
- Sub-module: calu_res_fifo (parametric FWFT FIFO, data+tag).

Test Plan:
- Single MUL, din_1={3,4}, din_2={1,2}, alu_dout from real complex_alu -> out_data={16'hFFFB,16'd10}, tag intact, accepted ALU_LAT+2 cycles before out_valid.
- MULADD, same operands with din_3={10,20} -> {16'd5,16'd30}; MULSUB -> {16'd15,16'd10}.
- 20 back-to-back mixed ops with out_ready=1 -> in_ready never drops, results in order, tags 0..F wrapping.
- out_ready=0 with continuous in_valid -> exactly RES_DEPTH ops accepted, in_ready=0 thereafter, no FIFO overflow; release gives in-order drain.
- opcode 011 -> err_illegal single pulse, no out entry, alu_cea2=0 that cycle.
- rst asserted with 3 ops in flight -> outputs 0 immediately; after release busy=0 and no stale result emerges.
